serial_tx_scheduler: RTL
========================

Name: serial_tx_scheduler

Overview:
- Round-robin scheduler that shares one serial transmitter (32-bit word in; Sample / StartTx / TxBusy / TxDone handshake) among NREQ requesters.
- Per transfer, sequences the transmitter: clear, load word, start, wait for completion. Then acknowledges the requester.
- Sits between the register/bus clients and the transmitter instance. The transmitter is clocked from the same Clk domain.

Parameters:
- NREQ, 4, number of requesters (2..8).
- TIMEOUT, 1024, max cycles from StartTx to TxDone before abort (>=4).
- IDW, $clog2(NREQ), width of grant index (derived, not overridable).

Ports:
- Clk  input  1  system clock, rising edge.
- ResetN  input  1  asynchronous, active-low reset.
- Req  input  NREQ  per-requester request level; held high until matching Ack.
- DataIn  input  NREQ*32  packed words; requester i at [32*i+31:32*i]; stable while Req[i] high.
- Ack  output  NREQ  one-cycle completion pulse to the granted requester.
- Err  output  1  one-cycle pulse, coincident with Ack, when the transfer timed out.
- GrantId  output  IDW  index of the current or last granted requester.
- Busy  output  1  high whenever the FSM is not in IDLE.
- TxData  output  32  word presented to the transmitter DataIn.
- TxClear  output  1  one-cycle reset pulse to the transmitter; clears its sticky TxDone/TxBusy.
- Sample  output  1  transmitter load strobe.
- StartTx  output  1  transmitter start strobe.
- TxBusy  input  1  transmitter busy.
- TxDone  input  1  transmitter done (sticky until TxClear).

Behaviour:
- Reset (ResetN low, async):
  - State IDLE.
  - Ack, Err, Busy, TxClear, Sample, StartTx = 0.
  - TxData = 0, GrantId = 0.
  - RR pointer = NREQ-1, so requester 0 has first priority.
  - Timeout counter = 0.
- States: IDLE, CLEAR, LOAD, START, WAIT_DONE, RELEASE.
- IDLE:
  - If any Req bit is high, the winner is the first set bit searching upward from pointer+1, modulo NREQ.
  - Register GrantId, capture that requester's word into TxData, update pointer to the winner, go to CLEAR.
  - If no Req bit is high, stay in IDLE.
- CLEAR: TxClear=1 for exactly one cycle -> LOAD.
- LOAD: Sample=1, StartTx=0 for one cycle -> START.
- START: StartTx=1, Sample=0 for one cycle; timeout counter cleared -> WAIT_DONE.
- WAIT_DONE:
  - Counter increments each cycle.
  - TxDone=1 -> RELEASE, Err=0.
  - Counter reaches TIMEOUT-1 with TxDone still 0 -> RELEASE with Err flagged.
- RELEASE:
  - Ack[GrantId]=1 for one cycle; Err=1 in the same cycle if timed out.
  - Next state is IDLE. Re-arbitration happens in the IDLE cycle after RELEASE, so there is at least one idle cycle between transfers.
- Sample and StartTx are never high in the same cycle; each is a single-cycle pulse.
- Latency:
  - Req seen in IDLE (cycle 0) -> TxClear at cycle 1, Sample at 2, StartTx at 3.
  - Ack at the cycle after TxDone is sampled high.
- TxData is held constant from capture until IDLE is re-entered. The FSM ignores changes on DataIn after capture.
- Req[i] dropped after grant: transfer still completes and Ack[i] still pulses; requester must tolerate it.
- Req[i] dropped before grant: never granted.
- Same requester holding Req continuously: the other requesters are still served in round-robin order. Worst-case wait is NREQ-1 transfers.
- TxDone already high when WAIT_DONE is entered: impossible after TxClear. If seen anyway, treated as completion.
- ResetN asserted mid-transfer: all strobes drop immediately, no Ack is issued, and the pointer is reinitialised.

Decomposition:
- Shared package serial_pkg:
  - state enum (6 states)
  - WORD_W=32
  - default TIMEOUT constant
- One sub-module, rr_arbiter:
  - inputs Req and pointer; outputs one-hot grant plus index.
  - Purely combinational priority rotate.
  - The pointer register lives in serial_tx_scheduler.

Test Plan:
- Single request: Req=4'b0001, DataIn[31:0]=32'hA5A5_0001; TxDone model asserts 40 cycles after StartTx -> TxClear@1, Sample@2 with TxData=A5A50001, StartTx@3, Ack=4'b0001 one cycle after TxDone, Err=0.
- Round-robin: Req=4'b1111 held, Ack each requester once served -> grant order 0,1,2,3,0; GrantId sequence matches; no requester served twice in a row.
- Timeout: TIMEOUT=16, transmitter never asserts TxDone -> Ack pulses with Err=1 exactly 16 cycles after StartTx; FSM back in IDLE next cycle.
- Strobe exclusivity: random traffic over 10k cycles -> assertion that Sample&StartTx never both high; each strobe is exactly 1 cycle wide.
- Reset mid-transfer: ResetN low during WAIT_DONE -> all outputs 0 asynchronously; no Ack; after release, Req=4'b0100 is granted first.
- Data stability: DataIn for the granted requester changes after the LOAD cycle -> TxData unchanged until IDLE.

Source files
------------

// File: rtl/serial_pkg.sv
// ---------------------------------------------------------------------------
// serial_pkg
//   Shared definitions for the serial transmitter scheduler.
//   - WORD_W          : width of one transmit word
//   - DEFAULT_TIMEOUT : default StartTx-to-TxDone abort limit in cycles
//   - state_t / ST_*  : scheduler FSM encoding, kept as plain constants so the
//                       encoding stays visible in waveforms and older tools
// ---------------------------------------------------------------------------
package serial_pkg;

    localparam int WORD_W          = 32;
    localparam int DEFAULT_TIMEOUT = 1024;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE      = 3'd0;
    localparam state_t ST_CLEAR     = 3'd1;
    localparam state_t ST_LOAD      = 3'd2;
    localparam state_t ST_START     = 3'd3;
    localparam state_t ST_WAIT_DONE = 3'd4;
    localparam state_t ST_RELEASE   = 3'd5;

endpackage

// File: rtl/serial_tx_scheduler_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//   Purely combinational round-robin priority rotate. The search starts at
//   the requester just above ptr_i and wraps modulo NREQ, so the requester
//   named by ptr_i has the lowest priority.
//   Ports:
//     req_i   [NREQ-1:0]  request levels
//     ptr_i   [IDW-1:0]   index of the last granted requester
//     grant_o [NREQ-1:0]  one-hot winner (all zero when no request)
//     idx_o   [IDW-1:0]   binary index of the winner
//     any_o               at least one request is pending
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IDW-1:0]  idx_o,
    output logic            any_o
);

    logic [IDW-1:0] cand;
    logic           found;

    // Walk the candidates ptr+1 .. ptr+NREQ (mod NREQ); the first one that is
    // requesting wins. The last candidate is ptr itself, so a lone requester
    // that was just served can still be granted again.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        cand    = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = IDW'((32'(ptr_i) + 32'(i)) % 32'(NREQ));
            if (!found && req_i[cand]) begin
                found         = 1'b1;
                grant_o[cand] = 1'b1;
                idx_o         = cand;
            end
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/serial_tx_scheduler.sv
// ---------------------------------------------------------------------------
// serial_tx_scheduler
//   Shares one serial transmitter among NREQ requesters in round-robin order.
//   Each transfer runs CLEAR -> LOAD -> START -> WAIT_DONE -> RELEASE and ends
//   with a one-cycle Ack to the granted requester (plus Err on timeout).
//   Ports:
//     Clk, ResetN         clock (rising edge), async active-low reset
//     Req     [NREQ]      request levels, held until the matching Ack
//     DataIn  [NREQ*32]   packed words, requester i at [32*i+31:32*i]
//     Ack     [NREQ]      one-cycle completion pulse
//     Err                 one-cycle pulse with Ack when the transfer timed out
//     GrantId [IDW]       current or last granted requester
//     Busy                FSM is not idle
//     TxData  [32]        captured word presented to the transmitter
//     TxClear             one-cycle transmitter clear pulse
//     Sample, StartTx     transmitter load and start strobes
//     TxBusy, TxDone      transmitter status (TxDone sticky until TxClear)
// ---------------------------------------------------------------------------
module serial_tx_scheduler
    import serial_pkg::*;
#(
    parameter  int NREQ    = 4,
    parameter  int TIMEOUT = DEFAULT_TIMEOUT,
    localparam int IDW     = $clog2(NREQ)
) (
    input  logic                   Clk,
    input  logic                   ResetN,
    input  logic [NREQ-1:0]        Req,
    input  logic [NREQ*WORD_W-1:0] DataIn,
    output logic [NREQ-1:0]        Ack,
    output logic                   Err,
    output logic [IDW-1:0]         GrantId,
    output logic                   Busy,
    output logic [WORD_W-1:0]      TxData,
    output logic                   TxClear,
    output logic                   Sample,
    output logic                   StartTx,
    input  logic                   TxBusy,
    input  logic                   TxDone
);

    localparam int CW = $clog2(TIMEOUT) + 1;

    state_t            state_q, state_d;
    logic [IDW-1:0]    ptr_q, ptr_d;
    logic [IDW-1:0]    grant_q, grant_d;
    logic [WORD_W-1:0] data_q, data_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              err_q, err_d;

    logic [NREQ-1:0]   winOh;
    logic [IDW-1:0]    winIdx;
    logic              anyReq;
    logic [WORD_W-1:0] winWord;

    // Completion is decided by the sticky TxDone alone; TxBusy is part of the
    // transmitter interface but carries no extra information for sequencing.
    logic unusedTxBusy;
    assign unusedTxBusy = TxBusy;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .req_i   (Req),
        .ptr_i   (ptr_q),
        .grant_o (winOh),
        .idx_o   (winIdx),
        .any_o   (anyReq)
    );

    // One-hot AND-OR mux of the winning requester's word; avoids a variable
    // part-select on the wide DataIn bus.
    always_comb begin
        winWord = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (winOh[i]) begin
                winWord = winWord | DataIn[WORD_W*i +: WORD_W];
            end
        end
    end

    // Next-state logic. The timeout compare uses TIMEOUT-2 because the
    // counter starts at 0 in the first WAIT_DONE cycle; this places the
    // aborting Ack exactly TIMEOUT cycles after the StartTx cycle.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (anyReq) begin
                    grant_d = winIdx;
                    ptr_d   = winIdx;
                    data_d  = winWord;
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                state_d = ST_START;
            end
            ST_START: begin
                cnt_d   = '0;
                err_d   = 1'b0;
                state_d = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (TxDone) begin
                    state_d = ST_RELEASE;
                end else if (cnt_q == CW'(TIMEOUT - 2)) begin
                    err_d   = 1'b1;
                    state_d = ST_RELEASE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers. Pointer resets to NREQ-1 so requester 0 goes first.
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            state_q <= ST_IDLE;
            ptr_q   <= IDW'(NREQ - 1);
            grant_q <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Strobes are pure state decodes, so they are single-cycle, mutually
    // exclusive and drop immediately on an asynchronous reset.
    always_comb begin
        Ack = '0;
        if (state_q == ST_RELEASE) begin
            for (int i = 0; i < NREQ; i++) begin
                Ack[i] = (grant_q == IDW'(i));
            end
        end
    end

    assign Err     = (state_q == ST_RELEASE) && err_q;
    assign Busy    = (state_q != ST_IDLE);
    assign TxClear = (state_q == ST_CLEAR);
    assign Sample  = (state_q == ST_LOAD);
    assign StartTx = (state_q == ST_START);
    assign TxData  = data_q;
    assign GrantId = grant_q;

endmodule
